tick_phase_sequencer: RTL

//  Parametrised successor to the fixed rate-divider and modulo counters. Generates a one-cycle

---
 rtl/tick_pkg.sv | 25 ++
 rtl/tick_phase_sequencer_mod_counter.sv | 45 ++++
 rtl/tick_phase_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tick_pkg.sv
// Shared constants for the tick/phase sequencer slice.
// Holds default widths and terminal counts for hardware and simulation builds,
// the phase-width helper, and the prescaler action decode type.
package tick_pkg;

  localparam int DIV_W_DEFAULT   = 25;
  localparam int DIV_DEFAULT_HW  = 6000000;
  localparam int DIV_DEFAULT_SIM = 3;
  localparam int PHASES_DEFAULT  = 5;
  localparam int COUNT_W_DEFAULT = 7;

  // Per-cycle prescaler action, already resolved by priority clear > load > enable.
  typedef enum logic [1:0] {
    PS_HOLD  = 2'd0,
    PS_RUN   = 2'd1,
    PS_LOAD  = 2'd2,
    PS_CLEAR = 2'd3
  } ps_act_e;

  // Bits needed to hold 0..phases-1; never narrower than one bit.
  function automatic int phase_width(input int phases);
    return (phases < 2) ? 1 : $clog2(phases);
  endfunction

endpackage

// File: rtl/tick_phase_sequencer_mod_counter.sv
// mod_counter: synchronous modulo-MOD up-counter with clear and increment.
// tc is a combinational wrap strobe (inc while at MOD-1, not cleared) so a
// following counter can advance on the very same edge this one wraps.
module mod_counter #(
  parameter int MOD = 5,
  parameter int W   = 3
) (
  input  logic         INPUTCLOCK,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         tc
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;
  logic         at_max;

  assign at_max = (value_q == W'(MOD - 1));

  // Next value: clear wins, then wrap-or-increment.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = at_max ? '0 : value_q + W'(1);
    end
  end

  // Wrap strobe seen by the next stage in the chain.
  assign tc    = inc & at_max & ~clr;
  assign value = value_q;

  // Counter register.
  always_ff @(posedge INPUTCLOCK or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/tick_phase_sequencer.sv
// tick_phase_sequencer: programmable tick divider driving a modulo-PHASES
// phase counter and a wrap-around frame counter, all on INPUTCLOCK.
// Optional feature macro: CLKOUT_TOGGLE_EN adds clkout, a square wave that
// toggles on every registered tick (forced low by clear/div_load).
module tick_phase_sequencer
  import tick_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DIV_DEFAULT = DIV_DEFAULT_HW,
  parameter int PHASES      = PHASES_DEFAULT,
  parameter int PHASE_W     = phase_width(PHASES),
  parameter int COUNT_W     = COUNT_W_DEFAULT
) (
  input  logic               INPUTCLOCK,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               clear,
  input  logic               div_load,
  input  logic [DIV_W-1:0]   div_value,
  output logic               tick,
  output logic [PHASE_W-1:0] phase,
  output logic               should_load,
  output logic [COUNT_W-1:0] count,
  output logic               count_wrap
`ifdef CLKOUT_TOGGLE_EN
  ,
  output logic               clkout
`endif
);

  ps_act_e            act;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_d;
  logic [DIV_W-1:0]   presc_q;
  logic [DIV_W-1:0]   presc_d;
  logic               tick_q;
  logic               tick_d;
  logic               count_wrap_q;
  logic               count_wrap_d;
  logic               phase_inc;
  logic               phase_tc;
  logic               count_tc;
  logic [PHASE_W-1:0] phase_val;
  logic [COUNT_W-1:0] count_val;

  // Resolve the control inputs into one action for this cycle.
  always_comb begin
    if (clear) begin
      act = PS_CLEAR;
    end else if (div_load) begin
      act = PS_LOAD;
    end else if (enable) begin
      act = PS_RUN;
    end else begin
      act = PS_HOLD;
    end
  end

  // Prescaler and tick next-state; tick is only ever produced by a terminal count.
  always_comb begin
    div_d   = div_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    case (act)
      PS_CLEAR: begin
        presc_d = '0;
      end
      PS_LOAD: begin
        div_d   = div_value;
        presc_d = '0;
      end
      PS_RUN: begin
        if (presc_q == div_q) begin
          presc_d = '0;
          tick_d  = 1'b1;
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      default: begin
        presc_d = presc_q;
      end
    endcase
  end

  // A registered tick advances the phase even if enable has since dropped;
  // a div_load in that cycle holds phase/count so reprogramming never steps them.
  assign phase_inc    = tick_q & (act != PS_LOAD);
  assign count_wrap_d = count_tc;

  mod_counter #(
    .MOD (PHASES),
    .W   (PHASE_W)
  ) u_phase (
    .INPUTCLOCK (INPUTCLOCK),
    .reset_n    (reset_n),
    .clr        (clear),
    .inc        (phase_inc),
    .value      (phase_val),
    .tc         (phase_tc)
  );

  mod_counter #(
    .MOD (1 << COUNT_W),
    .W   (COUNT_W)
  ) u_count (
    .INPUTCLOCK (INPUTCLOCK),
    .reset_n    (reset_n),
    .clr        (clear),
    .inc        (phase_tc),
    .value      (count_val),
    .tc         (count_tc)
  );

  // Divider register, prescaler and registered pulse outputs.
  always_ff @(posedge INPUTCLOCK or negedge reset_n) begin
    if (!reset_n) begin
      div_q        <= DIV_W'(DIV_DEFAULT);
      presc_q      <= '0;
      tick_q       <= 1'b0;
      count_wrap_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      count_wrap_q <= count_wrap_d;
    end
  end

  assign tick        = tick_q;
  assign phase       = phase_val;
  assign should_load = (phase_val == '0);
  assign count       = count_val;
  assign count_wrap  = count_wrap_q;

`ifdef CLKOUT_TOGGLE_EN
  logic clkout_q;
  logic clkout_d;

  // Square wave: flip on each registered tick, restart low on clear/reload.
  always_comb begin
    if ((act == PS_CLEAR) || (act == PS_LOAD)) begin
      clkout_d = 1'b0;
    end else begin
      clkout_d = clkout_q ^ tick_q;
    end
  end

  // Clock-out register.
  always_ff @(posedge INPUTCLOCK or negedge reset_n) begin
    if (!reset_n) begin
      clkout_q <= 1'b0;
    end else begin
      clkout_q <= clkout_d;
    end
  end

  assign clkout = clkout_q;
`endif

endmodule
